// File: rtl/pattern_pkg.sv
// pattern_pkg
// Shared definitions for the serial pattern-match controller:
//   - state_e        : controller states (IDLE, LOAD, SCAN, DONE)
//   - DEF_PAT_W      : default pattern width
//   - DEF_CNT_W      : default match-counter / target width
//   - DEF_TMO_W      : default timeout-counter width
package pattern_pkg;

    localparam int DEF_PAT_W = 5;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TMO_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/pattern_shift_match.sv
// pattern_shift_match
// Serial shift register, fill counter and pattern comparator.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   clr           : clear shift register and fill counter
//   shift_en      : a serial bit is accepted this cycle
//   bit_in        : serial data bit
//   pattern       : pattern to detect
//   hit           : accepted bit completes a window equal to pattern
module pattern_shift_match
    import pattern_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] L_FILL_FULL  = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] L_FILL_PRIME = FILL_W'(PAT_W - 1);
    localparam logic [FILL_W-1:0] L_FILL_ONE   = FILL_W'(1);

    logic [PAT_W-1:0]  r_shift;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_window;

    // Newest bit enters at the MSB; the oldest bit of the window sits at the LSB.
    assign w_window = {bit_in, r_shift[PAT_W-1:1]};

    // A window is only meaningful once PAT_W bits (including this one) have arrived.
    assign hit = shift_en && (r_fill >= L_FILL_PRIME) && (w_window == pattern);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (clr) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else if (shift_en) begin
            r_shift <= w_window;
            if (r_fill != L_FILL_FULL) begin
                r_fill <= r_fill + L_FILL_ONE;
            end
        end
    end

endmodule

// File: rtl/pattern_seq_ctrl.sv
// pattern_seq_ctrl
// Controller for the serial pattern-match datapath. Accepts a configuration
// (pattern, target count, timeout) over a valid/ready handshake, streams
// serial bits into the match engine, counts overlapping matches and ends a
// run with a one-cycle done pulse and a timeout flag.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   cfg_valid / cfg_ready       : configuration handshake (ready only in IDLE)
//   cfg_pattern/count/timeout   : configuration fields, latched on accept
//   bit_valid / bit_ready       : serial bit handshake (ready only in SCAN)
//   bit_in                      : serial data bit
//   abort                       : cancel the current run, back to IDLE
//   busy                        : controller not in IDLE
//   match_pulse                 : one-cycle pulse per counted match (registered)
//   match_cnt                   : matches counted in current/last run
//   done                        : one-cycle pulse at the end of a run
//   timed_out                   : run ended by timeout; held until next accept
module pattern_seq_ctrl
    import pattern_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMO_W = DEF_TMO_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    input  logic             abort,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             timed_out
);

    localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);
    localparam logic [TMO_W-1:0] L_TMO_ONE = TMO_W'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [PAT_W-1:0] r_pattern;
    logic [CNT_W-1:0] r_target;
    logic [TMO_W-1:0] r_timeout;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_match_pulse;
    logic             r_timed_out;

    logic             w_accept_cfg;
    logic             w_shift_en;
    logic             w_clr;
    logic             w_hit;
    logic             w_count_hit;
    logic             w_final;
    logic             w_tmo_exp;

    assign w_accept_cfg = (r_state == IDLE) && cfg_valid;
    assign w_shift_en   = (r_state == SCAN) && bit_valid;
    assign w_clr        = (r_state == LOAD);

    pattern_shift_match #(
        .PAT_W (PAT_W)
    ) u_shift_match (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (w_clr),
        .shift_en (w_shift_en),
        .bit_in   (bit_in),
        .pattern  (r_pattern),
        .hit      (w_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the per-cycle SCAN decisions. abort outranks hit and
    // timeout, and a final hit outranks a coincident timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_count_hit = 1'b0;
        w_final     = 1'b0;
        w_tmo_exp   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cfg_valid) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (r_target == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_count_hit = w_hit;
                    w_final     = w_hit && ((r_match_cnt + L_CNT_ONE) == r_target);
                    // tmo_cnt counts SCAN cycles from 0, so T-1 marks the T-th cycle.
                    w_tmo_exp   = (r_timeout != '0) && (r_tmo_cnt == (r_timeout - L_TMO_ONE));
                    if (w_final || w_tmo_exp) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern     <= '0;
            r_target      <= '0;
            r_timeout     <= '0;
            r_tmo_cnt     <= '0;
            r_match_cnt   <= '0;
            r_match_pulse <= 1'b0;
            r_timed_out   <= 1'b0;
        end else begin
            r_match_pulse <= w_count_hit;

            if (w_accept_cfg) begin
                r_pattern   <= cfg_pattern;
                r_target    <= cfg_count;
                r_timeout   <= cfg_timeout;
                r_match_cnt <= '0;
                r_timed_out <= 1'b0;
            end else if (w_count_hit) begin
                r_match_cnt <= r_match_cnt + L_CNT_ONE;
            end

            if (r_state == LOAD) begin
                r_tmo_cnt <= '0;
            end else if (r_state == SCAN) begin
                r_tmo_cnt <= r_tmo_cnt + L_TMO_ONE;
            end

            if (w_tmo_exp && !w_final) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign cfg_ready   = (r_state == IDLE);
    assign bit_ready   = (r_state == SCAN);
    assign busy        = (r_state != IDLE);
    // An abort arriving in the DONE cycle cancels the completion report.
    assign done        = (r_state == DONE) && !abort;
    assign match_pulse = r_match_pulse;
    assign match_cnt   = r_match_cnt;
    assign timed_out   = r_timed_out;

endmodule

// File: tb/tb_pattern_seq_ctrl.sv
// tb_pattern_seq_ctrl
// Directed scenarios plus randomized traffic for pattern_seq_ctrl, compared
// every cycle against a behavioural model built on a bit-history queue.
module tb_pattern_seq_ctrl;

    localparam int PW = 5;
    localparam int CW = 8;
    localparam int TW = 16;
    localparam logic [13:0] RESET_OUTS = 14'b10_0000_0000_0000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pattern;
    logic [CW-1:0] cfg_count;
    logic [TW-1:0] cfg_timeout;
    logic          bit_valid;
    logic          bit_in;
    logic          bit_ready;
    logic          abort;
    logic          busy;
    logic          match_pulse;
    logic [CW-1:0] match_cnt;
    logic          done;
    logic          timed_out;

    always #5 clk = ~clk;

    pattern_seq_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_pattern (cfg_pattern),
        .cfg_count   (cfg_count),
        .cfg_timeout (cfg_timeout),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .bit_ready   (bit_ready),
        .abort       (abort),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_cnt   (match_cnt),
        .done        (done),
        .timed_out   (timed_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 load, 2 scan, 3 done.
    int            m_phase;
    logic [PW-1:0] m_pat;
    int            m_tgt;
    int            m_tmo;
    int            m_cnt;
    int            m_scan;
    bit            m_to;
    bit            m_pulse;
    bit            m_hist[$];
    int            pulse_seen;
    int            done_seen;

    task automatic model_reset();
        m_phase = 0; m_pat = '0; m_tgt = 0; m_tmo = 0; m_cnt = 0;
        m_scan = 0; m_to = 0; m_pulse = 0;
        m_hist.delete();
    endtask

    function automatic logic [13:0] model_outs();
        logic [CW-1:0] c;
        c = CW'(m_cnt);
        return {m_phase == 0, m_phase == 2, m_phase != 0,
                (m_phase == 3) && !abort, m_pulse, m_to, c};
    endfunction

    task automatic model_step();
        bit            hit;
        logic [PW-1:0] win;
        int            n;
        case (m_phase)
            0: begin
                m_pulse = 0;
                if (cfg_valid) begin
                    m_pat = cfg_pattern; m_tgt = cfg_count; m_tmo = cfg_timeout;
                    m_cnt = 0; m_to = 0; m_phase = 1;
                end
            end
            1: begin
                m_pulse = 0;
                m_hist.delete();
                m_scan = 0;
                m_phase = abort ? 0 : ((m_tgt == 0) ? 3 : 2);
            end
            2: begin
                hit = 0;
                if (bit_valid) begin
                    m_hist.push_back(bit_in);
                    if (m_hist.size() > 2 * PW) void'(m_hist.pop_front());
                    n = m_hist.size();
                    // Only windows of PW bits accepted since load can match.
                    if (n >= PW || m_scan_bits_enough()) begin
                        if (n >= PW) begin
                            for (int i = 0; i < PW; i++) win[i] = m_hist[n - PW + i];
                            hit = (win == m_pat);
                        end
                    end
                end
                if (abort) begin
                    m_phase = 0; m_pulse = 0;
                end else begin
                    m_pulse = hit;
                    if (hit) m_cnt++;
                    if (hit && m_cnt == m_tgt) begin
                        m_phase = 3; m_to = 0;
                    end else if (m_tmo != 0 && m_scan + 1 == m_tmo) begin
                        m_phase = 3; m_to = 1;
                    end
                    m_scan++;
                end
            end
            default: begin
                m_pulse = 0; m_phase = 0;
            end
        endcase
    endtask

    function automatic bit m_scan_bits_enough();
        return 1'b0;
    endfunction

    // Called just after a falling edge with this cycle's inputs in place.
    task automatic cycle();
        #1;
        check("outs", {cfg_ready, bit_ready, busy, done, match_pulse, timed_out, match_cnt},
              model_outs());
        if (match_pulse) pulse_seen++;
        if (done) done_seen++;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic cv, input logic bv, input logic b, input logic ab);
        cfg_valid = cv; bit_valid = bv; bit_in = b; abort = ab;
        cycle();
    endtask

    task automatic set_cfg(input logic [PW-1:0] p, input logic [CW-1:0] c, input logic [TW-1:0] t);
        cfg_pattern = p; cfg_count = c; cfg_timeout = t;
    endtask

    task automatic start_run(input logic [PW-1:0] p, input logic [CW-1:0] c, input logic [TW-1:0] t);
        set_cfg(p, c, t);
        drive(1, 0, 0, 0);   // accept in IDLE
        drive(0, 0, 0, 0);   // LOAD
    endtask

    logic [4:0] seq;
    int         scan;

    initial begin
        reset_n = 1'b0;
        cfg_valid = 0; bit_valid = 0; bit_in = 0; abort = 0;
        set_cfg('0, '0, '0);
        model_reset();
        #1;
        check("reset_outs", {cfg_ready, bit_ready, busy, done, match_pulse, timed_out, match_cnt},
              RESET_OUTS);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);

        // Single match on bits 0,1,1,0,1.
        pulse_seen = 0;
        start_run(5'b10110, 8'd1, 16'd0);
        seq = 5'b10110;
        for (int i = 0; i < 5; i++) drive(0, 1, seq[i], 0);
        check("single_done", done, 1);
        check("single_cnt", match_cnt, 1);
        check("single_to", timed_out, 0);
        drive(0, 0, 0, 0);
        check("single_pulses", pulse_seen, 1);
        check("single_ready", cfg_ready, 1);

        // Overlapping matches of all-zero pattern; priming suppresses bits 1-4.
        pulse_seen = 0;
        start_run(5'b00000, 8'd3, 16'd0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
        check("prime_cnt", match_cnt, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
        check("overlap_done", done, 1);
        check("overlap_cnt", match_cnt, 3);
        drive(0, 0, 0, 0);
        check("overlap_pulses", pulse_seen, 3);

        // Timeout after exactly 20 SCAN cycles.
        start_run(5'b11111, 8'd1, 16'd20);
        scan = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bit_ready) scan++;
            drive(0, 1, 0, 0);
        end
        check("tmo_done", done, 1);
        check("tmo_scan_cycles", scan, 20);
        check("tmo_flag", timed_out, 1);
        check("tmo_cnt", match_cnt, 0);
        drive(0, 0, 0, 0);

        // Final hit on the same cycle as timeout: success wins.
        start_run(5'b10110, 8'd1, 16'd5);
        for (int i = 0; i < 5; i++) drive(0, 1, seq[i], 0);
        check("tie_done", done, 1);
        check("tie_flag", timed_out, 0);
        check("tie_cnt", match_cnt, 1);
        drive(0, 0, 0, 0);

        // Abort on the third SCAN cycle.
        done_seen = 0;
        start_run(5'b10110, 8'd3, 16'd0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 1);
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_ready", cfg_ready, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
        check("abort_no_done", done_seen, 0);

        // Asynchronous reset mid-SCAN.
        start_run(5'b00000, 8'd2, 16'd0);
        for (int i = 0; i < 6; i++) drive(0, 1, 0, 0);
        reset_n = 1'b0;
        #1;
        check("rst_mid_outs", {cfg_ready, bit_ready, busy, done, match_pulse, timed_out, match_cnt},
              RESET_OUTS);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, 0, 0);

        // Zero target: done two cycles after accept.
        start_run(5'b01010, 8'd0, 16'd0);
        check("zero_done", done, 1);
        check("zero_cnt", match_cnt, 0);
        drive(0, 0, 0, 0);

        // Randomized traffic.
        done_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       cfg_pattern = 5'b00000;
                1:       cfg_pattern = 5'b11111;
                2:       cfg_pattern = 5'b10101;
                default: cfg_pattern = PW'($urandom);
            endcase
            cfg_count   = CW'($urandom_range(0, 4));
            cfg_timeout = ($urandom_range(0, 2) == 0) ? 16'd0 : TW'($urandom_range(1, 40));
            drive($urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 9) < 9) ? m_pat[m_hist.size() % PW] : 1'($urandom),
                  $urandom_range(0, 79) == 0);
        end
        check("rand_runs_done", done_seen > 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_seq_ctrl.md
# pattern_seq_ctrl

Controller for the serial 5-bit pattern-match datapath. It accepts a configuration (pattern, target match count, timeout) through a valid/ready handshake and loads the match engine. It then streams gated serial bits into the engine, suppresses matches until the shift register is primed, and counts overlapping matches. It finishes with a one-cycle done pulse carrying the match count and a timeout flag. It sits between the host/config logic and the serial bit source.

## Interface
- PAT_W, 5, pattern width in bits
- CNT_W, 8, match-counter and target width
- TMO_W, 16, timeout-counter width; timeout value 0 = no timeout
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  high only in IDLE
- cfg_pattern  in  PAT_W  pattern to detect
- cfg_count  in  CNT_W  target number of matches
- cfg_timeout  in  TMO_W  SCAN-cycle budget, 0 = unlimited
- bit_valid  in  1  serial bit offered
- bit_in  in  1  serial data bit
- bit_ready  out  1  high only in SCAN
- abort  in  1  cancel run, return to IDLE
- busy  out  1  state != IDLE
- match_pulse  out  1  registered one-cycle pulse per counted match
- match_cnt  out  CNT_W  matches counted in current/last run
- done  out  1  one-cycle pulse at end of a run (not on abort)
- timed_out  out  1  valid with done; held until next cfg accept

## Operation
- States: IDLE, LOAD, SCAN, DONE.
- IDLE to LOAD on cfg_valid && cfg_ready. Pattern, count and timeout are latched at that edge. match_cnt and timed_out are cleared at that edge.
- LOAD (1 cycle): clears the shift register, fill counter and tmo_cnt. Goes to DONE if cfg_count == 0, else to SCAN.
- SCAN: a bit is accepted when bit_valid && bit_ready.
  - The shift register updates as shift <= {bit_in, shift[PAT_W-1:1]}, so the first bit ends at the LSB.
  - fill saturates at PAT_W.
- hit = accepted && fill >= PAT_W-1 && {bit_in, shift[PAT_W-1:1]} == pattern.
  - Overlapping matches count.
  - No hit is possible before PAT_W bits have been accepted since LOAD.
- On hit: match_cnt increments at the same edge, and match_pulse goes high the following cycle.
- tmo_cnt increments every SCAN cycle, whether or not a bit is accepted.
- SCAN to DONE on the final hit (match_cnt+1 == target). timed_out = 0.
- SCAN to DONE when timeout != 0 and tmo_cnt == timeout-1 with no final hit. timed_out = 1.
- Final hit and timeout on the same cycle: success wins, timed_out = 0.
- DONE (1 cycle): done = 1, then IDLE. match_cnt holds until the next cfg accept.
- abort in LOAD/SCAN/DONE: next state IDLE, no done pulse, match_cnt holds. abort in IDLE is ignored.
- abort has priority over hit and timeout in the same cycle.
- match_cnt never exceeds target, so no wrap is possible.

## Timing
- Reset values: cfg_ready = 1, bit_ready = 0, busy = 0, match_pulse = 0, match_cnt = 0, done = 0, timed_out = 0. State = IDLE; shift, fill, tmo_cnt and latched config all 0.
- Reset mid-run returns to IDLE immediately (asynchronously); no done pulse.
- Config accept edge E: LOAD in cycle E+1, SCAN from cycle E+2.
- Final matching bit accepted at edge F: done high in cycle F+1, cfg_ready high from cycle F+2.
- Timeout T: SCAN lasts exactly T cycles.
- bit_ready and cfg_ready are pure state decodes, with no combinational path from any input.

## Structure
- Package pattern_pkg holds:
  - the state enum (IDLE, LOAD, SCAN, DONE);
  - default PAT_W/CNT_W/TMO_W constants.
- One sub-module, pattern_shift_match: shift register, fill counter, and the compare producing hit. Inputs: clk, reset_n, clr, shift_en, bit_in, pattern.
- Controller FSM and counters live in pattern_seq_ctrl.

## Test plan
- Reset: check every output against its reset value, then deassert reset_n. cfg_ready = 1 and nothing else toggles for 10 cycles.
- Single match: pattern 5'b10110, count 1, timeout 0; stream bits 0,1,1,0,1.
  - One match_pulse; match_cnt = 1; done one cycle after the 5th bit; timed_out = 0.
- Overlap and priming: pattern 5'b00000, count 3; stream 7 zeros.
  - No hit on bits 1–4; hits on bits 5, 6, 7; done after bit 7 with match_cnt = 3.
- Timeout: pattern 5'b11111, count 1, timeout 20; bit_valid held with zeros.
  - done after exactly 20 SCAN cycles, timed_out = 1, match_cnt = 0.
- Tie: pattern 5'b10110, count 1, timeout 5; bits 0,1,1,0,1 valid every SCAN cycle.
  - Final hit coincides with timeout; timed_out = 0, match_cnt = 1.
- Abort/reset/zero count:
  - abort on the 3rd SCAN cycle: IDLE next cycle, no done.
  - reset_n pulse mid-SCAN: all outputs return to reset values.
  - count 0: done 2 cycles after accept with match_cnt = 0.
